// File: rtl/slink_app_pkg.sv
// ---------------------------------------------------------------------------
// slink_app_pkg
// Shared constants and types for the S-Link application-side packet monitor.
//   SHORT_LONG_THRESHOLD : data IDs below this value are short packets
//   HDR_BYTES            : header bytes per packet (data_id, wc[7:0], wc[15:8])
//   state_t              : receive parser state
// ---------------------------------------------------------------------------
package slink_app_pkg;

  localparam logic [7:0] SHORT_LONG_THRESHOLD = 8'h20;
  localparam int         HDR_BYTES            = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  function automatic logic is_long_pkt(input logic [7:0] data_id);
    return (data_id >= SHORT_LONG_THRESHOLD);
  endfunction

endpackage

// File: rtl/slink_exp_byte_fifo.sv
// ---------------------------------------------------------------------------
// slink_exp_byte_fifo
// Expected-byte FIFO: one push per cycle, 0..PEEK pops per cycle, with the
// first PEEK entries visible combinationally so a whole beat can be compared
// against the head in one cycle.
// Ports:
//   link_clk   : clock, rising edge
//   link_reset : asynchronous active-low reset (empties the FIFO)
//   i_push     : push i_byte (dropped when full, flagged on o_drop)
//   i_byte     : byte to push
//   i_pop_cnt  : number of entries to pop this cycle (must not exceed level)
//   o_peek     : entries rd_ptr+0 .. rd_ptr+PEEK-1, entry k at [8k+7:8k]
//   o_level    : occupancy
//   o_full     : level == DEPTH
//   o_empty    : level == 0
//   o_drop     : push attempted while full (this cycle)
// ---------------------------------------------------------------------------
module slink_exp_byte_fifo #(
  parameter  int DEPTH = 64,
  parameter  int PEEK  = 7,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(PEEK + 1)
) (
  input  logic              link_clk,
  input  logic              link_reset,
  input  logic              i_push,
  input  logic [7:0]        i_byte,
  input  logic [PW-1:0]     i_pop_cnt,
  output logic [PEEK*8-1:0] o_peek,
  output logic [LW-1:0]     o_level,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_drop
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push_ok;

  // Fullness is judged before this cycle's pops, so a push into a full FIFO
  // is dropped even if entries leave in the same cycle.
  assign w_push_ok = i_push && (r_level != LW'(DEPTH));
  assign o_drop    = i_push && !w_push_ok;
  assign o_level   = r_level;
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge link_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_byte;
    end
  end

  always_ff @(posedge link_clk or negedge link_reset) begin
    if (!link_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= r_rd_ptr + AW'(i_pop_cnt);
      r_level  <= r_level + LW'(w_push_ok) - LW'(i_pop_cnt);
    end
  end

  // Power-of-two depth: pointer arithmetic wraps naturally.
  genvar gi;
  generate
    for (gi = 0; gi < PEEK; gi++) begin : g_peek
      assign o_peek[gi*8 +: 8] = r_mem[r_rd_ptr + AW'(gi)];
    end
  endgenerate

endmodule

// File: rtl/slink_app_pkt_monitor.sv
// ---------------------------------------------------------------------------
// slink_app_pkt_monitor
// Receive-side checker for the S-Link application interface. Expected bytes
// are queued in a FIFO; every received packet (header + payload) is compared
// byte-by-byte against the FIFO head and error statistics are accumulated.
// Ports:
//   link_clk, link_reset       : clock / async active-low reset
//   exp_push, exp_byte         : expected-byte stream into the FIFO
//   rx_sop, rx_data_id,
//   rx_word_count, rx_app_data,
//   rx_valid, rx_crc_corrupted : RX app interface being checked
//   exp_level/full/empty       : FIFO status
//   pkt_done                   : one-cycle pulse per completed packet
//   *_count                    : saturating statistics counters
//   overflow                   : sticky, push seen while FIFO full
//   error                      : any nonzero error counter or overflow
// ---------------------------------------------------------------------------
module slink_app_pkt_monitor
  import slink_app_pkg::*;
#(
  parameter int APP_DATA_WIDTH = 32,
  parameter int EXP_DEPTH      = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      link_clk,
  input  logic                      link_reset,
  input  logic                      exp_push,
  input  logic [7:0]                exp_byte,
  input  logic                      rx_sop,
  input  logic [7:0]                rx_data_id,
  input  logic [15:0]               rx_word_count,
  input  logic [APP_DATA_WIDTH-1:0] rx_app_data,
  input  logic                      rx_valid,
  input  logic                      rx_crc_corrupted,
  output logic [$clog2(EXP_DEPTH):0] exp_level,
  output logic                      exp_full,
  output logic                      exp_empty,
  output logic                      pkt_done,
  output logic [CNT_WIDTH-1:0]      pkt_count,
  output logic [CNT_WIDTH-1:0]      mismatch_count,
  output logic [CNT_WIDTH-1:0]      underflow_count,
  output logic [CNT_WIDTH-1:0]      crc_err_count,
  output logic [CNT_WIDTH-1:0]      sop_err_count,
  output logic                      overflow,
  output logic                      error
);

  localparam int NB   = APP_DATA_WIDTH / 8;
  localparam int NCMP = NB + HDR_BYTES;
  localparam int PW   = $clog2(NCMP + 1);
  localparam int LW   = $clog2(EXP_DEPTH) + 1;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PW-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  state_t               r_state;
  logic [15:0]          r_rem;
  logic                 r_crc;
  logic                 r_done;
  logic                 r_overflow;
  logic                 r_error;
  logic [CNT_WIDTH-1:0] r_pkt_cnt, r_mis_cnt, r_und_cnt, r_crc_cnt, r_sop_cnt;

  logic [NCMP*8-1:0]    w_cmp_bytes;
  logic [NCMP*8-1:0]    w_peek;
  logic [NCMP-1:0]      w_mis_bit;
  logic [LW-1:0]        w_level;
  logic                 w_full, w_empty, w_drop;
  logic                 w_sop_beat, w_pay_beat, w_stray_beat, w_long, w_sop_err;
  logic [PW-1:0]        w_n, w_avail, w_under, w_mis;
  logic                 w_done, w_crc_hit, w_crc_next;
  state_t               w_state_next;
  logic [15:0]          w_rem_next;
  logic [CNT_WIDTH-1:0] w_pkt_next, w_mis_next, w_und_next, w_crc_cnt_next, w_sop_next;
  logic                 w_overflow_next;

  slink_exp_byte_fifo #(
    .DEPTH (EXP_DEPTH),
    .PEEK  (NCMP)
  ) u_fifo (
    .link_clk   (link_clk),
    .link_reset (link_reset),
    .i_push     (exp_push),
    .i_byte     (exp_byte),
    .i_pop_cnt  (w_avail),
    .o_peek     (w_peek),
    .o_level    (w_level),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_drop     (w_drop)
  );

  assign w_sop_beat   = rx_valid && rx_sop;
  assign w_pay_beat   = rx_valid && !rx_sop && (r_state == PAYLOAD);
  assign w_stray_beat = rx_valid && !rx_sop && (r_state == IDLE);
  assign w_long       = is_long_pkt(rx_data_id);
  // A sop arriving mid-payload abandons the old packet; it is then parsed as new.
  assign w_sop_err    = (w_sop_beat && (r_state == PAYLOAD)) || w_stray_beat;

  // Byte k of the beat lines up with FIFO entry rd_ptr+k. On a sop beat the
  // header occupies slots 0..2 and payload lanes follow; on a payload beat
  // the lanes start at slot 0.
  genvar gi;
  generate
    for (gi = 0; gi < NCMP; gi++) begin : g_cmp
      logic [7:0] w_sop_byte;
      logic [7:0] w_pay_byte;
      if (gi == 0) begin : g_di
        assign w_sop_byte = rx_data_id;
      end else if (gi == 1) begin : g_wcl
        assign w_sop_byte = rx_word_count[7:0];
      end else if (gi == 2) begin : g_wch
        assign w_sop_byte = rx_word_count[15:8];
      end else begin : g_sl
        assign w_sop_byte = rx_app_data[(gi-HDR_BYTES)*8 +: 8];
      end
      if (gi < NB) begin : g_lane
        assign w_pay_byte = rx_app_data[gi*8 +: 8];
      end else begin : g_pad
        assign w_pay_byte = 8'h00;
      end
      assign w_cmp_bytes[gi*8 +: 8] = w_sop_beat ? w_sop_byte : w_pay_byte;
      assign w_mis_bit[gi] = (PW'(gi) < w_avail) &&
                             (w_cmp_bytes[gi*8 +: 8] != w_peek[gi*8 +: 8]);
    end
  endgenerate

  // Parser: how many bytes this beat carries and where the packet goes next.
  always_comb begin
    w_n          = '0;
    w_done       = 1'b0;
    w_crc_hit    = 1'b0;
    w_crc_next   = r_crc;
    w_state_next = r_state;
    w_rem_next   = r_rem;
    if (w_sop_beat) begin
      // Sticky CRC bit restarts on every sop, including this beat's flag.
      w_crc_next = rx_crc_corrupted;
      if (!w_long) begin
        w_n          = PW'(HDR_BYTES);
        w_done       = 1'b1;
        w_state_next = IDLE;
      end else if (rx_word_count <= 16'(NB)) begin
        w_n          = PW'(HDR_BYTES) + PW'(rx_word_count);
        w_done       = 1'b1;
        w_crc_hit    = rx_crc_corrupted;
        w_state_next = IDLE;
      end else begin
        w_n          = PW'(NCMP);
        w_rem_next   = rx_word_count - 16'(NB);
        w_state_next = PAYLOAD;
      end
    end else if (w_pay_beat) begin
      w_crc_next = r_crc | rx_crc_corrupted;
      if (r_rem <= 16'(NB)) begin
        w_n          = PW'(r_rem);
        w_done       = 1'b1;
        w_crc_hit    = w_crc_next;
        w_state_next = IDLE;
      end else begin
        w_n        = PW'(NB);
        w_rem_next = r_rem - 16'(NB);
      end
    end
  end

  // Only bytes that have a FIFO entry are compared and popped; the rest count
  // as underflow.
  always_comb begin
    w_avail = (LW'(w_n) <= w_level) ? w_n : PW'(w_level);
    w_under = w_n - w_avail;
    w_mis   = '0;
    for (int k = 0; k < NCMP; k++) begin
      w_mis = w_mis + PW'(w_mis_bit[k]);
    end
  end

  assign w_pkt_next      = sat_add(r_pkt_cnt, PW'(w_done));
  assign w_mis_next      = sat_add(r_mis_cnt, w_mis);
  assign w_und_next      = sat_add(r_und_cnt, w_under);
  assign w_crc_cnt_next  = sat_add(r_crc_cnt, PW'(w_crc_hit));
  assign w_sop_next      = sat_add(r_sop_cnt, PW'(w_sop_err));
  assign w_overflow_next = r_overflow | w_drop;

  always_ff @(posedge link_clk or negedge link_reset) begin
    if (!link_reset) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_crc      <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
      r_pkt_cnt  <= '0;
      r_mis_cnt  <= '0;
      r_und_cnt  <= '0;
      r_crc_cnt  <= '0;
      r_sop_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rem      <= w_rem_next;
      r_crc      <= w_crc_next;
      r_done     <= w_done;
      r_overflow <= w_overflow_next;
      r_pkt_cnt  <= w_pkt_next;
      r_mis_cnt  <= w_mis_next;
      r_und_cnt  <= w_und_next;
      r_crc_cnt  <= w_crc_cnt_next;
      r_sop_cnt  <= w_sop_next;
      // Built from next-state values so error lines up with the counters.
      r_error    <= w_overflow_next || (w_mis_next != '0) || (w_und_next != '0) ||
                    (w_crc_cnt_next != '0) || (w_sop_next != '0);
    end
  end

  assign exp_level       = w_level;
  assign exp_full        = w_full;
  assign exp_empty       = w_empty;
  assign pkt_done        = r_done;
  assign pkt_count       = r_pkt_cnt;
  assign mismatch_count  = r_mis_cnt;
  assign underflow_count = r_und_cnt;
  assign crc_err_count   = r_crc_cnt;
  assign sop_err_count   = r_sop_cnt;
  assign overflow        = r_overflow;
  assign error           = r_error;

endmodule

// File: tb/tb_slink_app_pkt_monitor.sv
// ---------------------------------------------------------------------------
// tb_slink_app_pkt_monitor
// Scoreboarded bench: when the completing beat of a packet is driven, the
// expected counter snapshot is queued; the pkt_done monitor pops and checks it.
// ---------------------------------------------------------------------------
module tb_slink_app_pkt_monitor;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int CW    = 16;

  logic          link_clk = 1'b0;
  logic          link_reset = 1'b0;
  logic          exp_push = 1'b0;
  logic [7:0]    exp_byte = '0;
  logic          rx_sop = 1'b0;
  logic [7:0]    rx_data_id = '0;
  logic [15:0]   rx_word_count = '0;
  logic [DW-1:0] rx_app_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_crc_corrupted = 1'b0;
  logic [$clog2(DEPTH):0] exp_level;
  logic          exp_full, exp_empty, pkt_done, overflow, error;
  logic [CW-1:0] pkt_count, mismatch_count, underflow_count, crc_err_count, sop_err_count;

  slink_app_pkt_monitor #(
    .APP_DATA_WIDTH (DW),
    .EXP_DEPTH      (DEPTH),
    .CNT_WIDTH      (CW)
  ) dut (
    .link_clk         (link_clk),
    .link_reset       (link_reset),
    .exp_push         (exp_push),
    .exp_byte         (exp_byte),
    .rx_sop           (rx_sop),
    .rx_data_id       (rx_data_id),
    .rx_word_count    (rx_word_count),
    .rx_app_data      (rx_app_data),
    .rx_valid         (rx_valid),
    .rx_crc_corrupted (rx_crc_corrupted),
    .exp_level        (exp_level),
    .exp_full         (exp_full),
    .exp_empty        (exp_empty),
    .pkt_done         (pkt_done),
    .pkt_count        (pkt_count),
    .mismatch_count   (mismatch_count),
    .underflow_count  (underflow_count),
    .crc_err_count    (crc_err_count),
    .sop_err_count    (sop_err_count),
    .overflow         (overflow),
    .error            (error)
  );

  always #5 link_clk = ~link_clk;

  typedef struct {
    int pkt;
    int mis;
    int und;
    int crc;
    int sop;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_pkt(input int pkt, input int mis, input int und, input int crc, input int sop);
    exp_t e;
    e.pkt = pkt; e.mis = mis; e.und = und; e.crc = crc; e.sop = sop;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: one line per completed packet.
  always @(negedge link_clk) begin
    exp_t e;
    if (link_reset && pkt_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pkt_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("pkt_done: pkt=%0d mis=%0d und=%0d crc=%0d sop=%0d", pkt_count,
                 mismatch_count, underflow_count, crc_err_count, sop_err_count);
        check("pkt_count", 32'(pkt_count), 32'(e.pkt));
        check("mismatch_count", 32'(mismatch_count), 32'(e.mis));
        check("underflow_count", 32'(underflow_count), 32'(e.und));
        check("crc_err_count", 32'(crc_err_count), 32'(e.crc));
        check("sop_err_count", 32'(sop_err_count), 32'(e.sop));
      end
    end
  end

  task automatic idle();
    @(negedge link_clk);
    exp_push = 1'b0;
    rx_valid = 1'b0;
    rx_sop = 1'b0;
    rx_crc_corrupted = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    link_reset = 1'b0;
    repeat (2) @(negedge link_clk);
    link_reset = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge link_clk);
    rx_valid = 1'b0;
    exp_push = 1'b1;
    exp_byte = b;
  endtask

  task automatic beat(input logic sop, input logic [7:0] di, input logic [15:0] wc,
                      input logic [31:0] data, input logic crc);
    @(negedge link_clk);
    exp_push = 1'b0;
    rx_valid = 1'b1;
    rx_sop = sop;
    rx_data_id = di;
    rx_word_count = wc;
    rx_app_data = data;
    rx_crc_corrupted = crc;
  endtask

  // Let pending pkt_done pulses drain, then confirm none is still owed.
  task automatic settle(input string tag);
    idle();
    repeat (3) @(negedge link_clk);
    check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_level", 32'(exp_level), 32'd0);
    check("rst_empty", 32'(exp_empty), 32'd1);
    check("rst_full", 32'(exp_full), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_pkt", 32'(pkt_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_error", 32'(error), 32'd0);

    // Short packet, clean
    push(8'h0A); push(8'h34); push(8'h12);
    expect_pkt(1, 0, 0, 0, 0);
    beat(1'b1, 8'h0A, 16'h1234, 32'h0, 1'b0);
    settle("short");
    check("short_empty", 32'(exp_empty), 32'd1);
    check("short_error", 32'(error), 32'd0);

    // Long packet wc=5 across two beats; upper lanes of last beat ignored
    do_reset();
    push(8'h25); push(8'h05); push(8'h00);
    for (int i = 0; i < 5; i++) push(8'(i));
    beat(1'b1, 8'h25, 16'd5, 32'h03020100, 1'b0);
    expect_pkt(1, 0, 0, 0, 0);
    beat(1'b0, 8'h00, 16'd0, 32'hAABBCC04, 1'b0);
    settle("long5");
    check("long5_level", 32'(exp_level), 32'd0);
    check("long5_error", 32'(error), 32'd0);

    // Same packet with payload byte 2 expected as 0xFF
    do_reset();
    push(8'h25); push(8'h05); push(8'h00);
    push(8'h00); push(8'h01); push(8'hFF); push(8'h03); push(8'h04);
    beat(1'b1, 8'h25, 16'd5, 32'h03020100, 1'b0);
    expect_pkt(1, 1, 0, 0, 0);
    beat(1'b0, 8'h00, 16'd0, 32'h00000004, 1'b0);
    settle("mis");
    check("mis_empty", 32'(exp_empty), 32'd1);
    check("mis_error", 32'(error), 32'd1);

    // CRC flagged on second beat of wc=8, then a clean long packet
    do_reset();
    push(8'h25); push(8'h08); push(8'h00);
    for (int i = 0; i < 8; i++) push(8'(i));
    push(8'h25); push(8'h04); push(8'h00);
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    beat(1'b1, 8'h25, 16'd8, 32'h03020100, 1'b0);
    expect_pkt(1, 0, 0, 1, 0);
    beat(1'b0, 8'h00, 16'd0, 32'h07060504, 1'b1);
    expect_pkt(2, 0, 0, 1, 0);
    beat(1'b1, 8'h25, 16'd4, 32'h13121110, 1'b0);
    settle("crc");
    check("crc_empty", 32'(exp_empty), 32'd1);

    // Short packet with nothing expected -> underflow
    do_reset();
    expect_pkt(1, 0, 3, 0, 0);
    beat(1'b1, 8'h05, 16'h0000, 32'h0, 1'b0);
    settle("under");
    check("under_error", 32'(error), 32'd1);
    check("under_empty", 32'(exp_empty), 32'd1);

    // FIFO overflow
    do_reset();
    for (int i = 0; i <= DEPTH; i++) push(8'(i));
    settle("ovf");
    check("ovf_full", 32'(exp_full), 32'd1);
    check("ovf_level", 32'(exp_level), 32'(DEPTH));
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_error", 32'(error), 32'd1);

    // New sop mid-payload, then a stray beat while idle
    do_reset();
    push(8'h25); push(8'h08); push(8'h00);
    for (int i = 0; i < 4; i++) push(8'(i));
    push(8'h0A); push(8'h11); push(8'h22);
    beat(1'b1, 8'h25, 16'd8, 32'h03020100, 1'b0);
    expect_pkt(1, 0, 0, 0, 1);
    beat(1'b1, 8'h0A, 16'h2211, 32'h0, 1'b0);
    settle("sop");
    check("sop_empty", 32'(exp_empty), 32'd1);
    beat(1'b0, 8'h00, 16'd0, 32'h12345678, 1'b0);
    settle("stray");
    check("stray_sop_err", 32'(sop_err_count), 32'd2);
    check("stray_pkt", 32'(pkt_count), 32'd1);
    check("stray_under", 32'(underflow_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
